vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Scan-out reader for the 320x240, 3-bit pixel framebuffer that the CPU fills via PLOT (XWrite/YWrite/writeValueMemory).
- Generates 640x480@60 Hz VGA timing from the 50 MHz system clock, with a pixel enable every second clock.
- Fetches each framebuffer pixel through the memory read port (XRead/YRead -> readValueMemory) with 2x2 pixel doubling.
- Drives the sync, blank and RGB pins and gives the CPU a once-per-frame pulse.

Parameters:
- ImageWidth, 320, framebuffer width in pixels.
- ImageHeight, 240, framebuffer height in pixels.
- ColorBits, 3, pixel width; bit2=R, bit1=G, bit0=B.
- HVisible/HFront/HSync/HBack, 640/16/96/48, horizontal timing in pixel ticks (total 800).
- VVisible/VFront/VSync/VBack, 480/10/2/33, vertical timing in lines (total 525).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- XRead  out  9  framebuffer read column.
- YRead  out  8  framebuffer read row.
- readValueMemory  in  ColorBits  read data, valid 1 clk after the address.
- vga_clk  out  1  25 MHz pixel clock; equals the phase register.
- vga_hsync  out  1  horizontal sync, active low.
- vga_vsync  out  1  vertical sync, active low.
- vga_blank_n  out  1  high in the visible region.
- vga_r, vga_g, vga_b  out  8 each  colour, with each colour bit replicated to 8 bits.
- frame_done  out  1  one-clk pulse at end of frame.

Behaviour:
- Reset values (reset low, takes effect immediately):
  - phase, h_cnt, v_cnt = 0.
  - vga_hsync = 1, vga_vsync = 1, vga_blank_n = 0.
  - RGB = 0, frame_done = 0, XRead = 0, YRead = 0.
- Phase and tick:
  - phase toggles every clk; tick = (phase == 1).
  - After reset release, the first tick occurs on the 2nd rising edge.
- Counters (update on tick only):
  - h_cnt 0..799 wraps to 0.
  - On the h_cnt wrap, v_cnt 0..524 increments and wraps to 0.
- Visible region: vis = (h_cnt < 640) && (v_cnt < 480).
- Read address (combinational from registered counters):
  - XRead = vis ? h_cnt[9:1] : 0.
  - YRead = vis ? v_cnt[8:1] : 0.
  - The address is stable for 2 clks, so data is valid by the next tick.
- Output registers (load on tick from pre-increment counters; one-pixel pipeline lag vs counters):
  - vga_hsync = !(656 <= h_cnt < 752).
  - vga_vsync = !(490 <= v_cnt < 492).
  - vga_blank_n = vis.
  - RGB = vis ? replicate(readValueMemory bits) : 0.
- frame_done: 1 clk high on the tick where h_cnt = 799 and v_cnt = 524; 0 otherwise.
- Between ticks, all outputs except vga_clk hold their values.
- Reset mid-frame: everything returns to reset values; scan-out restarts at (0,0) after release. No partial-frame pulse is emitted.
- Out-of-range read data (X ≥ ImageWidth) cannot occur: max XRead = 319, max YRead = 239.
- The block never writes memory; the read port is independent of CPU PLOT writes (dual-port RAM).
- Tearing on a mid-frame write is acceptable.

Decomposition:
- Shared package vga_pkg holds:
  - timing localparams: H_TOTAL = 800, V_TOTAL = 525, sync start/end constants;
  - color_t, a typedef logic [ColorBits-1:0];
  - the color-expand function.
- One sub-module, vga_timing: phase, counters, vis, sync flags, frame_done.
- vga_scanout instantiates vga_timing and owns address generation and the output registers.

Test Plan:
- Reset / first tick: hold reset low 5 clks, then release.
  - While low: hsync = vsync = 1, blank_n = 0, RGB = 0.
  - vga_clk rises on the 1st edge after release.
  - First tick on the 2nd edge.
- Horizontal timing: run one line.
  - hsync falls at clk edge 1314 after release (tick 657, h_cnt = 656).
  - hsync stays low for exactly 192 clks.
  - Line period is 1600 clks.
- Vertical / frame timing: run two frames.
  - vsync is low for exactly 2 lines (3200 clks).
  - frame_done is a single-clk pulse every 840000 clks.
- Pixel doubling: memory model returns (X+Y)%8 with 1-clk latency.
  - Output pixels 2 and 3 of line 0 both show colour 1 (B: vga_b = 8'hFF, R = G = 0).
  - Line 1 matches line 0; line 2 pixel 0 shows colour 1.
- Blanking: model drives 3'b111 constantly.
  - RGB = 0 and blank_n = 0 for all h_cnt ≥ 640 and v_cnt ≥ 480.
  - XRead = YRead = 0 there.
- Mid-frame reset: assert reset at line 100, pixel 300.
  - Outputs return to reset values asynchronously, within the same clk.
  - After release the timing restarts from (0,0) and the next frame_done comes 840000 clks later.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants, pixel type and colour expansion for the VGA scan-out path.
package vga_pkg;

    localparam int ImageWidth  = 320;
    localparam int ImageHeight = 240;
    localparam int ColorBits   = 3;

    localparam int H_VISIBLE    = 640;
    localparam int H_FRONT      = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BACK       = 48;
    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int V_VISIBLE    = 480;
    localparam int V_FRONT      = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef logic [ColorBits-1:0] color_t;

    // Each colour bit drives a full 8-bit DAC channel: bit2=R, bit1=G, bit0=B.
    function automatic logic [23:0] color_expand(input color_t c);
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate phase, horizontal/vertical counters and the combinational
// visible/sync flags derived from them, plus the end-of-frame pulse.
module vga_timing
    import vga_pkg::*;
#(
    parameter int HVisible = H_VISIBLE,
    parameter int HFront   = H_FRONT,
    parameter int HSync    = H_SYNC,
    parameter int HBack    = H_BACK,
    parameter int VVisible = V_VISIBLE,
    parameter int VFront   = V_FRONT,
    parameter int VSync    = V_SYNC,
    parameter int VBack    = V_BACK
) (
    input  logic       clk,
    input  logic       reset,
    output logic       o_phase,
    output logic       o_tick,
    output logic [9:0] o_h_cnt,
    output logic [9:0] o_v_cnt,
    output logic       o_vis,
    output logic       o_hsync_n,
    output logic       o_vsync_n,
    output logic       o_frame_done
);

    localparam logic [9:0] H_VIS   = 10'(HVisible);
    localparam logic [9:0] H_SS    = 10'(HVisible + HFront);
    localparam logic [9:0] H_SE    = 10'(HVisible + HFront + HSync);
    localparam logic [9:0] H_LAST  = 10'(HVisible + HFront + HSync + HBack - 1);
    localparam logic [9:0] V_VIS   = 10'(VVisible);
    localparam logic [9:0] V_SS    = 10'(VVisible + VFront);
    localparam logic [9:0] V_SE    = 10'(VVisible + VFront + VSync);
    localparam logic [9:0] V_LAST  = 10'(VVisible + VFront + VSync + VBack - 1);

    logic       r_phase;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_frame_done;
    logic       w_tick;
    logic       w_h_last;
    logic       w_v_last;

    assign w_tick   = r_phase;
    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase      <= 1'b0;
            r_h_cnt      <= '0;
            r_v_cnt      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_phase      <= ~r_phase;
            // Cleared on the non-tick clock so the pulse is exactly one clk wide.
            r_frame_done <= w_tick && w_h_last && w_v_last;
            if (w_tick) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
            end
        end
    end

    assign o_phase      = r_phase;
    assign o_tick       = w_tick;
    assign o_h_cnt      = r_h_cnt;
    assign o_v_cnt      = r_v_cnt;
    assign o_vis        = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign o_hsync_n    = !((r_h_cnt >= H_SS) && (r_h_cnt < H_SE));
    assign o_vsync_n    = !((r_v_cnt >= V_SS) && (r_v_cnt < V_SE));
    assign o_frame_done = r_frame_done;

endmodule

// File: rtl/vga_scanout.sv
// 640x480 VGA scan-out of the 320x240 framebuffer with 2x2 pixel doubling:
// drives the memory read address and registers sync/blank/RGB once per pixel tick.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int HVisible = H_VISIBLE,
    parameter int HFront   = H_FRONT,
    parameter int HSync    = H_SYNC,
    parameter int HBack    = H_BACK,
    parameter int VVisible = V_VISIBLE,
    parameter int VFront   = V_FRONT,
    parameter int VSync    = V_SYNC,
    parameter int VBack    = V_BACK
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [8:0]           XRead,
    output logic [7:0]           YRead,
    input  logic [ColorBits-1:0] readValueMemory,
    output logic                 vga_clk,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic                 vga_blank_n,
    output logic [7:0]           vga_r,
    output logic [7:0]           vga_g,
    output logic [7:0]           vga_b,
    output logic                 frame_done
);

    logic        w_phase;
    logic        w_tick;
    logic [9:0]  w_h_cnt;
    logic [9:0]  w_v_cnt;
    logic        w_vis;
    logic        w_hsync_n;
    logic        w_vsync_n;
    logic        w_frame_done;
    logic        w_unused;

    logic        r_hsync;
    logic        r_vsync;
    logic        r_blank_n;
    logic [23:0] r_rgb;

    vga_timing #(
        .HVisible(HVisible), .HFront(HFront), .HSync(HSync), .HBack(HBack),
        .VVisible(VVisible), .VFront(VFront), .VSync(VSync), .VBack(VBack)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .o_phase     (w_phase),
        .o_tick      (w_tick),
        .o_h_cnt     (w_h_cnt),
        .o_v_cnt     (w_v_cnt),
        .o_vis       (w_vis),
        .o_hsync_n   (w_hsync_n),
        .o_vsync_n   (w_vsync_n),
        .o_frame_done(w_frame_done)
    );

    // Dropping the counter LSBs doubles each framebuffer pixel in both directions.
    assign XRead    = w_vis ? w_h_cnt[9:1] : 9'd0;
    assign YRead    = w_vis ? w_v_cnt[8:1] : 8'd0;
    assign w_unused = ^{w_h_cnt[0], w_v_cnt[9], w_v_cnt[0]};

    // The address has been stable for two clks by the tick, so the read data matches it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_blank_n <= 1'b0;
            r_rgb     <= '0;
        end else if (w_tick) begin
            r_hsync   <= w_hsync_n;
            r_vsync   <= w_vsync_n;
            r_blank_n <= w_vis;
            r_rgb     <= w_vis ? color_expand(readValueMemory) : 24'd0;
        end
    end

    assign vga_clk     = w_phase;
    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;
    assign vga_blank_n = r_blank_n;
    assign vga_r       = r_rgb[23:16];
    assign vga_g       = r_rgb[15:8];
    assign vga_b       = r_rgb[7:0];
    assign frame_done  = w_frame_done;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench: a full-size instance checked against a vector table and line-timing
// sequences, and a reduced-timing instance whose frames are short enough to run whole.
module tb_vga_scanout;

    logic clk;
    logic rst_a, rst_b;

    logic [8:0] xr_a, xr_b;
    logic [7:0] yr_a, yr_b;
    logic [2:0] mem_a, mem_b;
    logic       vclk_a, hs_a, vs_a, bl_a, fd_a;
    logic       vclk_b, hs_b, vs_b, bl_b, fd_b;
    logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;

    int n_checks = 0;
    int n_fail   = 0;

    vga_scanout u_dut_a (
        .clk(clk), .reset(rst_a), .XRead(xr_a), .YRead(yr_a), .readValueMemory(mem_a),
        .vga_clk(vclk_a), .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_blank_n(bl_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .frame_done(fd_a)
    );

    // Reduced timing: 32 ticks per line (sync 20..27), 15 lines per frame (sync 10..11).
    vga_scanout #(
        .HVisible(16), .HFront(4), .HSync(8), .HBack(4),
        .VVisible(8),  .VFront(2), .VSync(2), .VBack(3)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .XRead(xr_b), .YRead(yr_b), .readValueMemory(mem_b),
        .vga_clk(vclk_b), .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_blank_n(bl_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .frame_done(fd_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Memory A returns (X+Y)%8 one clk after the address; memory B is always white.
    initial mem_a = 3'd0;
    always @(posedge clk) mem_a <= xr_a[2:0] + yr_a[2:0];
    assign mem_b = 3'b111;

    typedef struct {
        int         cyc;
        logic       vclk;
        logic       hs;
        logic       vs;
        logic       bl;
        logic [2:0] col;
        logic       fd;
        logic [8:0] x;
        logic [7:0] y;
    } vec_t;

    function automatic logic [63:0] pack(input logic vc, input logic hs, input logic vs,
                                         input logic bl, input logic [23:0] rgb,
                                         input logic fd, input logic [8:0] x,
                                         input logic [7:0] y);
        return {18'd0, vc, hs, vs, bl, rgb, fd, x, y};
    endfunction

    function automatic logic [23:0] expand(input logic [2:0] c);
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       vecs[22];
        int         cyc;
        logic       prev;
        int         k;
        int         t, h, v, p, hp, vp;
        int         fd_cnt, vs_low;
        logic       e_hs, e_vs, e_bl, e_fd, vis;
        logic [8:0] e_x;
        logic [7:0] e_y;
        logic [63:0] rst_vec;

        //            cyc   vclk hs vs bl col fd x    y
        vecs[0]  = '{1,    1, 1, 1, 0, 0, 0, 0,   0};
        vecs[1]  = '{2,    0, 1, 1, 1, 0, 0, 0,   0};
        vecs[2]  = '{3,    1, 1, 1, 1, 0, 0, 0,   0};
        vecs[3]  = '{4,    0, 1, 1, 1, 0, 0, 1,   0};
        vecs[4]  = '{6,    0, 1, 1, 1, 1, 0, 1,   0};
        vecs[5]  = '{7,    1, 1, 1, 1, 1, 0, 1,   0};
        vecs[6]  = '{8,    0, 1, 1, 1, 1, 0, 2,   0};
        vecs[7]  = '{10,   0, 1, 1, 1, 2, 0, 2,   0};
        vecs[8]  = '{14,   0, 1, 1, 1, 3, 0, 3,   0};
        vecs[9]  = '{1278, 0, 1, 1, 1, 7, 0, 319, 0};
        vecs[10] = '{1280, 0, 1, 1, 1, 7, 0, 0,   0};
        vecs[11] = '{1282, 0, 1, 1, 0, 0, 0, 0,   0};
        vecs[12] = '{1312, 0, 1, 1, 0, 0, 0, 0,   0};
        vecs[13] = '{1314, 0, 0, 1, 0, 0, 0, 0,   0};
        vecs[14] = '{1504, 0, 0, 1, 0, 0, 0, 0,   0};
        vecs[15] = '{1506, 0, 1, 1, 0, 0, 0, 0,   0};
        vecs[16] = '{1600, 0, 1, 1, 0, 0, 0, 0,   0};
        vecs[17] = '{1602, 0, 1, 1, 1, 0, 0, 0,   0};
        vecs[18] = '{1606, 0, 1, 1, 1, 1, 0, 1,   0};
        vecs[19] = '{3200, 0, 1, 1, 0, 0, 0, 0,   1};
        vecs[20] = '{3202, 0, 1, 1, 1, 1, 0, 0,   1};
        vecs[21] = '{3206, 0, 1, 1, 1, 2, 0, 1,   1};

        rst_vec = pack(1'b0, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 9'd0, 8'd0);

        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) step();
        check("a_reset", pack(vclk_a, hs_a, vs_a, bl_a, {r_a, g_a, b_a}, fd_a, xr_a, yr_a), rst_vec);
        check("b_reset", pack(vclk_b, hs_b, vs_b, bl_b, {r_b, g_b, b_b}, fd_b, xr_b, yr_b), rst_vec);

        // Full-size instance: directed vectors from reset release.
        @(negedge clk);
        rst_a = 1'b1;
        cyc = 0;
        foreach (vecs[i]) begin
            while (cyc < vecs[i].cyc) begin
                step();
                cyc++;
            end
            check($sformatf("a_vec_cyc%0d", vecs[i].cyc),
                  pack(vclk_a, hs_a, vs_a, bl_a, {r_a, g_a, b_a}, fd_a, xr_a, yr_a),
                  pack(vecs[i].vclk, vecs[i].hs, vecs[i].vs, vecs[i].bl, expand(vecs[i].col),
                       vecs[i].fd, vecs[i].x, vecs[i].y));
        end

        // Next hsync fall is two line periods after the first one (1314).
        k = 0;
        prev = hs_a;
        while (k < 2000) begin
            prev = hs_a;
            step();
            cyc++;
            k++;
            if (prev && !hs_a) break;
        end
        check("a_hsync_fall_cyc", 64'(cyc), 64'd4514);
        k = 0;
        while (!hs_a && k < 400) begin
            step();
            k++;
        end
        check("a_hsync_low_clks", 64'(k), 64'd192);

        // Reset asserted between edges must clear the outputs without a clock.
        #4;
        rst_a = 1'b0;
        #1;
        check("a_async_reset", pack(vclk_a, hs_a, vs_a, bl_a, {r_a, g_a, b_a}, fd_a, xr_a, yr_a), rst_vec);

        // Reduced-timing instance: every clk of two frames against the timing equations.
        @(negedge clk);
        rst_b = 1'b1;
        fd_cnt = 0;
        vs_low = 0;
        for (int n = 1; n <= 1930; n++) begin
            step();
            t = n / 2;
            h = t % 32;
            v = (t / 32) % 15;
            vis = (h < 16) && (v < 8);
            e_x = vis ? 9'(h / 2) : 9'd0;
            e_y = vis ? 8'(v / 2) : 8'd0;
            if (t == 0) begin
                e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_fd = 1'b0;
            end else begin
                p  = t - 1;
                hp = p % 32;
                vp = (p / 32) % 15;
                e_hs = !(hp >= 20 && hp < 28);
                e_vs = !(vp >= 10 && vp < 12);
                e_bl = (hp < 16) && (vp < 8);
                e_fd = (n % 2 == 0) && (hp == 31) && (vp == 14);
            end
            check($sformatf("b_scan_n%0d", n),
                  pack(vclk_b, hs_b, vs_b, bl_b, {r_b, g_b, b_b}, fd_b, xr_b, yr_b),
                  pack(1'(n % 2), e_hs, e_vs, e_bl, e_bl ? 24'hFFFFFF : 24'd0, e_fd, e_x, e_y));
            if (fd_b) fd_cnt++;
            if (n <= 960 && !vs_b) vs_low++;
        end
        check("b_vsync_low_clks", 64'(vs_low), 64'd128);
        check("b_frame_done_count", 64'(fd_cnt), 64'd2);

        // Mid-frame reset on the reduced instance, then a full frame to the next pulse.
        repeat (370) step();
        #4;
        rst_b = 1'b0;
        #1;
        check("b_async_reset", pack(vclk_b, hs_b, vs_b, bl_b, {r_b, g_b, b_b}, fd_b, xr_b, yr_b), rst_vec);
        repeat (3) step();
        check("b_reset_hold", pack(vclk_b, hs_b, vs_b, bl_b, {r_b, g_b, b_b}, fd_b, xr_b, yr_b), rst_vec);
        @(negedge clk);
        rst_b = 1'b1;
        k = 0;
        while (k < 1200) begin
            step();
            k++;
            if (fd_b) break;
        end
        check("b_restart_frame_done_clks", 64'(k), 64'd960);
        step();
        check("b_frame_done_width", 64'(fd_b), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
